// File: rtl/audio_pkg.sv
// Shared audio-path constants: sample width, I2S frame geometry and clock-divider tap positions.
// Used by the note generator, the speaker transmitter and the top level.
package audio_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int FRAME_CYC = 512;
  localparam int CNT_W     = 9;

  localparam int MCLK_BIT  = 1;
  localparam int SCK_BIT   = 3;
  localparam int LRCK_BIT  = 8;

  localparam logic [CNT_W-1:0] CAPTURE_CNT = CNT_W'(FRAME_CYC - 1);

  // Word loaded into the shift register at frame capture; mute blanks both channels.
  function automatic logic [2*SAMPLE_W-1:0] frame_word(
    input logic [SAMPLE_W-1:0] left,
    input logic [SAMPLE_W-1:0] right,
    input logic                mute
  );
    return mute ? '0 : {left, right};
  endfunction

endpackage

// File: rtl/i2s_speaker_tx.sv
// Serializes a 16-bit stereo sample pair onto CS4344 I2S pins (MCLK/LRCK/SCK/SDIN).
// Every output is derived from a single free-running 9-bit frame counter.
module i2s_speaker_tx
  import audio_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] audio_left,
  input  logic [SAMPLE_W-1:0] audio_right,
  input  logic                mute,
  output logic                audio_mclk,
  output logic                audio_lrck,
  output logic                audio_sck,
  output logic                audio_sdin,
  output logic                sample_req
);

  localparam logic [CNT_W-1:0] PRE_CAPTURE_CNT = CAPTURE_CNT - CNT_W'(1);

  logic [CNT_W-1:0]      cnt_reg;
  logic [2*SAMPLE_W-1:0] sr_reg;
  logic                  sdin_reg;
  logic                  sample_req_reg;

  logic capture;
  logic bit_end;

  assign capture = (cnt_reg == CAPTURE_CNT);
  assign bit_end = &cnt_reg[SCK_BIT:0];

  // sdin is updated on the last cycle of each SCK period, so it moves as SCK falls
  // and the I2S one-bit delay falls out of the capture landing on a bit_end cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      sr_reg         <= '0;
      sdin_reg       <= 1'b0;
      sample_req_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_reg + CNT_W'(1);
      sample_req_reg <= (cnt_reg == PRE_CAPTURE_CNT);
      if (bit_end)
        sdin_reg <= sr_reg[2*SAMPLE_W-1];
      if (capture)
        sr_reg <= frame_word(audio_left, audio_right, mute);
      else if (bit_end)
        sr_reg <= sr_reg << 1;
    end
  end

  assign audio_mclk = cnt_reg[MCLK_BIT];
  assign audio_sck  = cnt_reg[SCK_BIT];
  assign audio_lrck = cnt_reg[LRCK_BIT];
  assign audio_sdin = sdin_reg;
  assign sample_req = sample_req_reg;

endmodule

// File: tb/tb_i2s_speaker_tx.sv
// Bench for i2s_speaker_tx: an independent frame-count model checks the clock pins every cycle,
// and a bit queue filled at each capture is drained at every SCK rise to check sdin.
module tb_i2s_speaker_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] audio_left = '0;
  logic [15:0] audio_right = '0;
  logic        mute = 1'b0;
  logic        audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_req;

  i2s_speaker_tx dut (
    .clk        (clk),
    .rst        (rst),
    .audio_left (audio_left),
    .audio_right(audio_right),
    .mute       (mute),
    .audio_mclk (audio_mclk),
    .audio_lrck (audio_lrck),
    .audio_sck  (audio_sck),
    .audio_sdin (audio_sdin),
    .sample_req (sample_req)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int req_pulses = 0;

  logic [8:0]  tb_cnt = '0;
  logic        rst_seen = 1'b0;
  logic        armed = 1'b0;
  logic        have_prev = 1'b0;
  logic        prev_sdin = 1'b0;
  logic [31:0] pending_exp = '0;
  logic        exp_q[$];

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        mute;
    logic [31:0] exp_word;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s at t=%0t cnt=%0d: got %h expected %h", name, $time, tb_cnt, act, exp);
    end
  endtask

  always @(posedge clk) begin
    tb_cnt   <= rst ? 9'd0 : tb_cnt + 9'd1;
    rst_seen <= rst;
    armed    <= armed | rst;
  end

  always @(negedge clk) begin
    if (armed) begin
      check("mclk", {31'd0, audio_mclk}, {31'd0, tb_cnt[1]});
      check("sck",  {31'd0, audio_sck},  {31'd0, tb_cnt[3]});
      check("lrck", {31'd0, audio_lrck}, {31'd0, tb_cnt[8]});
      check("sample_req", {31'd0, sample_req}, {31'd0, (tb_cnt == 9'd511)});
      if (sample_req === 1'b1) req_pulses++;
      if (rst_seen)
        check("reset_outputs", {27'd0, audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_req}, 32'd0);
      if (have_prev && tb_cnt[3:0] != 4'd0)
        check("sdin_stable", {31'd0, audio_sdin}, {31'd0, prev_sdin});
      prev_sdin = audio_sdin;
      have_prev = 1'b1;
      if (!rst_seen && tb_cnt[3:0] == 4'd12) begin
        if (exp_q.size() == 0) begin
          check("sdin_queue_empty", 32'd1, 32'd0);
        end else begin
          logic e;
          e = exp_q.pop_front();
          check($sformatf("sdin_slot%0d", tb_cnt[8:4]), {31'd0, audio_sdin}, {31'd0, e});
        end
      end
      if (rst) begin
        exp_q.delete();
        for (int i = 0; i < 33; i++) exp_q.push_back(1'b0);
      end else if (tb_cnt == 9'd511) begin
        for (int i = 31; i >= 0; i--) exp_q.push_back(pending_exp[i]);
      end
    end
  end

  task automatic wait_cnt(input int v);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (tb_cnt != 9'(v) && n < 2000);
    if (tb_cnt != 9'(v)) check("wait_cnt_timeout", {23'd0, tb_cnt}, 32'(v));
  endtask

  task automatic reset_and_check_first_req(input int hold);
    int n;
    rst = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    @(negedge clk);
    while (sample_req !== 1'b1 && n < 600) begin
      n++;
      @(negedge clk);
    end
    check("first_req_latency", 32'(n), 32'd511);
  endtask

  initial begin
    int start_pulses;
    vecs[0] = '{16'hA5C3, 16'h0F0F, 1'b0, 32'hA5C3_0F0F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0000};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFF_FFFF};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 32'h8000_0001};
    vecs[4] = '{16'h0000, 16'hFFFF, 1'b0, 32'h0000_FFFF};
    vecs[5] = '{16'h1234, 16'h8001, 1'b1, 32'h0000_0000};
    vecs[6] = '{16'hDEAD, 16'hBEEF, 1'b0, 32'hDEAD_BEEF};

    // Power-on reset, then a mid-frame reset around cnt = 200 with live data in flight.
    reset_and_check_first_req(3);
    wait_cnt(100);
    audio_left = 16'h5A5A; audio_right = 16'hC3C3; pending_exp = 32'h5A5A_C3C3;
    wait_cnt(200);
    audio_left = 16'h0000; audio_right = 16'h0000; pending_exp = 32'h0;
    reset_and_check_first_req(3);

    // Table-driven frames: inputs change mid-frame and are held through the next capture.
    for (int v = 0; v < 7; v++) begin
      wait_cnt(100);
      audio_left  = vecs[v].l;
      audio_right = vecs[v].r;
      mute        = vecs[v].mute;
      pending_exp = vecs[v].exp_word;
      $display("vector %0d: L=%h R=%h mute=%0d expect word %h", v, vecs[v].l, vecs[v].r, vecs[v].mute, vecs[v].exp_word);
      wait_cnt(0);
    end

    // Mute asserted mid-frame must not corrupt the word already in flight.
    wait_cnt(100);
    audio_left = 16'hFFFF; audio_right = 16'hFFFF; mute = 1'b0; pending_exp = 32'hFFFF_FFFF;
    wait_cnt(0);
    wait_cnt(300);
    mute = 1'b1; pending_exp = 32'h0;
    wait_cnt(0);
    wait_cnt(300);
    mute = 1'b0; pending_exp = 32'hFFFF_FFFF;
    wait_cnt(0);

    // Sample update race: change during the capture cycle is taken this frame.
    wait_cnt(100);
    audio_left = 16'h1234; audio_right = 16'h5555; pending_exp = 32'h1234_5555;
    wait_cnt(511);
    audio_left = 16'h8001; pending_exp = 32'h8001_5555;
    $display("race: L changed at cnt=511");
    wait_cnt(0);
    wait_cnt(100);
    audio_left = 16'h1234; pending_exp = 32'h1234_5555;
    wait_cnt(0);
    audio_left = 16'h8001; pending_exp = 32'h8001_5555;
    $display("race: L changed at cnt=0");

    // Ten frames: exactly one sample_req pulse each.
    start_pulses = req_pulses;
    for (int f = 0; f < 10; f++) wait_cnt(0);
    check("req_pulses_10_frames", 32'(req_pulses - start_pulses), 32'd10);

    wait_cnt(100);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
